// File: rtl/credit_pkg.sv
// credit_pkg
// Shared definitions for the credit accumulator: change-coin type encoding,
// bit positions inside the coin_in pulse vector, the FSM state type and the
// default unit values (one unit = 5 cents).
package credit_pkg;

  // Change coin type as presented to the hopper.
  typedef enum logic [1:0] {
    NICKEL  = 2'd0,
    DIME    = 2'd1,
    QUARTER = 2'd2
  } coin_type_e;

  // Bit positions in coin_in = {dollar, quarter, dime, nickel}.
  localparam int NICKEL_BIT  = 0;
  localparam int DIME_BIT    = 1;
  localparam int QUARTER_BIT = 2;
  localparam int DOLLAR_BIT  = 3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPENSE = 1'b1
  } state_e;

  // Default configuration.
  localparam int DEF_CREDIT_W      = 8;
  localparam int DEF_MAX_CREDIT    = 200;
  localparam int DEF_DOLLAR_UNITS  = 20;
  localparam int DEF_QUARTER_UNITS = 5;
  localparam int DEF_DIME_UNITS    = 2;
  localparam int DEF_NICKEL_UNITS  = 1;

endpackage

// File: rtl/credit_accumulator_change_selector.sv
// change_selector
// Combinational choice of the next change coin: the largest of
// quarter/dime/nickel whose value does not exceed the remaining credit.
// Ports:
//   credit_i      remaining credit in units
//   coin_type_o   selected coin type (NICKEL when credit is below a dime)
//   coin_value_o  unit value of the selected coin
module change_selector
  import credit_pkg::*;
#(
  parameter int CREDIT_W      = DEF_CREDIT_W,
  parameter int QUARTER_UNITS = DEF_QUARTER_UNITS,
  parameter int DIME_UNITS    = DEF_DIME_UNITS,
  parameter int NICKEL_UNITS  = DEF_NICKEL_UNITS
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output coin_type_e          coin_type_o,
  output logic [CREDIT_W-1:0] coin_value_o
);

  localparam logic [CREDIT_W-1:0] Q_UNITS = CREDIT_W'(QUARTER_UNITS);
  localparam logic [CREDIT_W-1:0] D_UNITS = CREDIT_W'(DIME_UNITS);
  localparam logic [CREDIT_W-1:0] N_UNITS = CREDIT_W'(NICKEL_UNITS);

  always_comb begin
    coin_type_o  = NICKEL;
    coin_value_o = N_UNITS;
    if (credit_i >= Q_UNITS) begin
      coin_type_o  = QUARTER;
      coin_value_o = Q_UNITS;
    end else if (credit_i >= D_UNITS) begin
      coin_type_o  = DIME;
      coin_value_o = D_UNITS;
    end
  end

endmodule

// File: rtl/credit_accumulator.sv
// credit_accumulator
// Accumulates coin credit (5-cent units) up to MAX_CREDIT, deducts a price on
// vend requests and pays the remaining credit back as change through a
// ready/valid handshake with the coin hopper.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   coin_in           one-cycle coin pulses {dollar, quarter, dime, nickel}
//   price, vend_req   purchase request and its price
//   refund_req        request to return all credit
//   hopper_ready      hopper takes the presented coin this cycle
//   credit            current credit
//   vend_ok/vend_fail purchase accepted / refused pulses
//   coin_reject       an inserted coin was not credited
//   coin_out_valid/coin_out_type  change coin presented to the hopper
//   refund_done       refund finished pulse
//   busy              high while dispensing change
module credit_accumulator
  import credit_pkg::*;
#(
  parameter int CREDIT_W      = DEF_CREDIT_W,
  parameter int MAX_CREDIT    = DEF_MAX_CREDIT,
  parameter int DOLLAR_UNITS  = DEF_DOLLAR_UNITS,
  parameter int QUARTER_UNITS = DEF_QUARTER_UNITS,
  parameter int DIME_UNITS    = DEF_DIME_UNITS,
  parameter int NICKEL_UNITS  = DEF_NICKEL_UNITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          coin_in,
  input  logic [CREDIT_W-1:0] price,
  input  logic                vend_req,
  input  logic                refund_req,
  input  logic                hopper_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_ok,
  output logic                vend_fail,
  output logic                coin_reject,
  output logic                coin_out_valid,
  output logic [1:0]          coin_out_type,
  output logic                refund_done,
  output logic                busy
);

  localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] DOL_U   = CREDIT_W'(DOLLAR_UNITS);
  localparam logic [CREDIT_W-1:0] QTR_U   = CREDIT_W'(QUARTER_UNITS);
  localparam logic [CREDIT_W-1:0] DIM_U   = CREDIT_W'(DIME_UNITS);
  localparam logic [CREDIT_W-1:0] NIC_U   = CREDIT_W'(NICKEL_UNITS);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_ok_q, vend_ok_d;
  logic                vend_fail_q, vend_fail_d;
  logic                coin_reject_q, coin_reject_d;
  logic                valid_q, valid_d;
  coin_type_e          type_q, type_d;
  logic [CREDIT_W-1:0] value_q, value_d;
  logic                refund_done_q, refund_done_d;
  logic                busy_q, busy_d;

  // Coin arbitration results.
  logic                coin_any;
  logic                coin_extra;
  logic [CREDIT_W-1:0] coin_val;

  // Intermediate IDLE arithmetic.
  logic [CREDIT_W-1:0] after_vend;
  logic [CREDIT_W:0]   coin_sum;

  coin_type_e          sel_type;
  logic [CREDIT_W-1:0] sel_value;

  // Highest-priority coin wins; any lower coin in the same pulse is surplus.
  always_comb begin
    coin_any   = |coin_in;
    coin_extra = 1'b0;
    coin_val   = '0;
    if (coin_in[DOLLAR_BIT]) begin
      coin_val   = DOL_U;
      coin_extra = |coin_in[QUARTER_BIT:NICKEL_BIT];
    end else if (coin_in[QUARTER_BIT]) begin
      coin_val   = QTR_U;
      coin_extra = |coin_in[DIME_BIT:NICKEL_BIT];
    end else if (coin_in[DIME_BIT]) begin
      coin_val   = DIM_U;
      coin_extra = coin_in[NICKEL_BIT];
    end else if (coin_in[NICKEL_BIT]) begin
      coin_val   = NIC_U;
    end
  end

  // Credit, FSM state and pulse outputs.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_ok_d     = 1'b0;
    vend_fail_d   = 1'b0;
    coin_reject_d = 1'b0;
    refund_done_d = 1'b0;
    after_vend    = credit_q;
    coin_sum      = '0;
    case (state_q)
      ST_IDLE: begin
        // Vend decision always uses the credit before this cycle's coin.
        if (vend_req) begin
          if (credit_q >= price) begin
            after_vend = credit_q - price;
            vend_ok_d  = 1'b1;
          end else begin
            vend_fail_d = 1'b1;
          end
        end
        if (refund_req && !vend_req) begin
          coin_reject_d = coin_any;
          if (credit_q != '0) begin
            state_d = ST_DISPENSE;
          end else begin
            refund_done_d = 1'b1;
          end
          credit_d = credit_q;
        end else begin
          coin_sum = {1'b0, after_vend} + {1'b0, coin_val};
          if (coin_any && (coin_sum <= MAX_EXT)) begin
            credit_d      = coin_sum[CREDIT_W-1:0];
            coin_reject_d = coin_extra;
          end else begin
            credit_d      = after_vend;
            coin_reject_d = coin_any;
          end
        end
      end
      ST_DISPENSE: begin
        coin_reject_d = coin_any;
        vend_fail_d   = vend_req;
        if (valid_q && hopper_ready) begin
          credit_d = credit_q - value_q;
          if (credit_d == '0) begin
            state_d       = ST_IDLE;
            refund_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The change coin is chosen from the credit that will hold after this edge,
  // so a new coin is presented right after each accepted one and the current
  // one stays put while the hopper stalls.
  change_selector #(
    .CREDIT_W      (CREDIT_W),
    .QUARTER_UNITS (QUARTER_UNITS),
    .DIME_UNITS    (DIME_UNITS),
    .NICKEL_UNITS  (NICKEL_UNITS)
  ) u_change_selector (
    .credit_i     (credit_d),
    .coin_type_o  (sel_type),
    .coin_value_o (sel_value)
  );

  always_comb begin
    valid_d = 1'b0;
    type_d  = NICKEL;
    value_d = '0;
    busy_d  = 1'b0;
    if (state_d == ST_DISPENSE) begin
      valid_d = 1'b1;
      type_d  = sel_type;
      value_d = sel_value;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      vend_ok_q     <= 1'b0;
      vend_fail_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      valid_q       <= 1'b0;
      type_q        <= NICKEL;
      value_q       <= '0;
      refund_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_ok_q     <= vend_ok_d;
      vend_fail_q   <= vend_fail_d;
      coin_reject_q <= coin_reject_d;
      valid_q       <= valid_d;
      type_q        <= type_d;
      value_q       <= value_d;
      refund_done_q <= refund_done_d;
      busy_q        <= busy_d;
    end
  end

  assign credit         = credit_q;
  assign vend_ok        = vend_ok_q;
  assign vend_fail      = vend_fail_q;
  assign coin_reject    = coin_reject_q;
  assign coin_out_valid = valid_q;
  assign coin_out_type  = type_q;
  assign refund_done    = refund_done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_credit_accumulator.sv
module tb_credit_accumulator;

  localparam int W = 8;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_NIC  = 4'b0001;
  localparam logic [3:0] C_DIM  = 4'b0010;
  localparam logic [3:0] C_QTR  = 4'b0100;
  localparam logic [3:0] C_DOL  = 4'b1000;

  localparam int T_N = 0;
  localparam int T_D = 1;
  localparam int T_Q = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   coin_in;
  logic [W-1:0] price;
  logic         vend_req;
  logic         refund_req;
  logic         hopper_ready;
  logic [W-1:0] credit;
  logic         vend_ok;
  logic         vend_fail;
  logic         coin_reject;
  logic         coin_out_valid;
  logic [1:0]   coin_out_type;
  logic         refund_done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    int credit;
    int ok;
    int fail;
    int rej;
    int valid;
    int ctype;
    int done;
    int busy;
  } exp_t;

  exp_t sb[$];

  credit_accumulator dut (
    .clk            (clk),
    .reset          (reset),
    .coin_in        (coin_in),
    .price          (price),
    .vend_req       (vend_req),
    .refund_req     (refund_req),
    .hopper_ready   (hopper_ready),
    .credit         (credit),
    .vend_ok        (vend_ok),
    .vend_fail      (vend_fail),
    .coin_reject    (coin_reject),
    .coin_out_valid (coin_out_valid),
    .coin_out_type  (coin_out_type),
    .refund_done    (refund_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int cr, int ok, int fl, int rj, int vl, int ty, int dn, int bs);
    exp_t e;
    e.credit = cr; e.ok = ok; e.fail = fl; e.rej = rj;
    e.valid = vl; e.ctype = ty; e.done = dn; e.busy = bs;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d observed=%0d expected=%0d", tag, step_no, obs, expv);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("credit", 32'(credit), e.credit);
    chk("vend_ok", 32'(vend_ok), e.ok);
    chk("vend_fail", 32'(vend_fail), e.fail);
    chk("coin_reject", 32'(coin_reject), e.rej);
    chk("coin_out_valid", 32'(coin_out_valid), e.valid);
    chk("coin_out_type", 32'(coin_out_type), e.ctype);
    chk("refund_done", 32'(refund_done), e.done);
    chk("busy", 32'(busy), e.busy);
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input logic [3:0] c, input int p, input logic v, input logic r,
                      input logic h, input exp_t e);
    exp_t got;
    coin_in      = c;
    price        = W'(p);
    vend_req     = v;
    refund_req   = r;
    hopper_ready = h;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    got = sb.pop_front();
    chk_all(got);
    $display("step %0d coin=%b price=%0d vend=%0d refund=%0d ready=%0d -> credit=%0d ok=%0d fail=%0d rej=%0d valid=%0d type=%0d done=%0d busy=%0d",
             step_no, c, p, v, r, h, credit, vend_ok, vend_fail, coin_reject,
             coin_out_valid, coin_out_type, refund_done, busy);
    coin_in    = C_NONE;
    vend_req   = 1'b0;
    refund_req = 1'b0;
  endtask

  task automatic idle(input logic h, input exp_t e);
    step(C_NONE, 0, 1'b0, 1'b0, h, e);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    chk_all(mk(0, 0, 0, 0, 0, 0, 0, 0));
    $display("reset asserted -> credit=%0d valid=%0d busy=%0d", credit, coin_out_valid, busy);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    coin_in      = C_NONE;
    price        = '0;
    vend_req     = 1'b0;
    refund_req   = 1'b0;
    hopper_ready = 1'b0;

    // 1: basic accumulation
    apply_reset();
    step(C_DOL, 0, 0, 0, 0, mk(20, 0, 0, 0, 0, T_N, 0, 0));
    step(C_NIC, 0, 0, 0, 0, mk(21, 0, 0, 0, 0, T_N, 0, 0));

    // 2: two coins at once, only the quarter counts
    apply_reset();
    step(C_QTR | C_DIM, 0, 0, 0, 0, mk(5, 0, 0, 1, 0, T_N, 0, 0));
    idle(0, mk(5, 0, 0, 0, 0, T_N, 0, 0));

    // 3: vending
    apply_reset();
    step(C_DOL, 0, 0, 0, 0, mk(20, 0, 0, 0, 0, T_N, 0, 0));
    step(C_DOL, 0, 0, 0, 0, mk(40, 0, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 35, 1, 0, 0, mk(5, 1, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 10, 1, 0, 0, mk(5, 0, 1, 0, 0, T_N, 0, 0));
    step(C_DIM, 5, 1, 0, 0, mk(2, 1, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 0, 1, 0, 0, mk(2, 1, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 2, 1, 1, 0, mk(0, 1, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 1, 1, 0, 0, mk(0, 0, 1, 0, 0, T_N, 0, 0));

    // 4: saturation at the ceiling
    apply_reset();
    for (int i = 1; i <= 9; i++) step(C_DOL, 0, 0, 0, 0, mk(20 * i, 0, 0, 0, 0, T_N, 0, 0));
    step(C_QTR, 0, 0, 0, 0, mk(185, 0, 0, 0, 0, T_N, 0, 0));
    step(C_QTR, 0, 0, 0, 0, mk(190, 0, 0, 0, 0, T_N, 0, 0));
    step(C_DOL, 0, 0, 0, 0, mk(190, 0, 0, 1, 0, T_N, 0, 0));
    step(C_QTR, 0, 0, 0, 0, mk(195, 0, 0, 0, 0, T_N, 0, 0));
    step(C_QTR, 0, 0, 0, 0, mk(200, 0, 0, 0, 0, T_N, 0, 0));
    step(C_NIC, 0, 0, 0, 0, mk(200, 0, 0, 1, 0, T_N, 0, 0));

    // 5: refund from zero credit, then full refund of 8 units with ready tied high
    apply_reset();
    step(C_NONE, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, T_N, 1, 0));
    step(C_QTR, 0, 0, 0, 1, mk(5, 0, 0, 0, 0, T_N, 0, 0));
    step(C_DIM, 0, 0, 0, 1, mk(7, 0, 0, 0, 0, T_N, 0, 0));
    step(C_NIC, 0, 0, 0, 1, mk(8, 0, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 0, 0, 1, 1, mk(8, 0, 0, 0, 1, T_Q, 0, 1));
    idle(1, mk(3, 0, 0, 0, 1, T_D, 0, 1));
    idle(1, mk(1, 0, 0, 0, 1, T_N, 0, 1));
    idle(1, mk(0, 0, 0, 0, 0, T_N, 1, 0));
    idle(1, mk(0, 0, 0, 0, 0, T_N, 0, 0));

    // 6a: hopper stall holds the quarter; inputs during dispense are refused
    apply_reset();
    step(C_QTR, 0, 0, 0, 0, mk(5, 0, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 0, 0, 1, 0, mk(5, 0, 0, 0, 1, T_Q, 0, 1));
    step(C_DIM, 0, 0, 0, 0, mk(5, 0, 0, 1, 1, T_Q, 0, 1));
    step(C_NONE, 0, 1, 0, 0, mk(5, 0, 1, 0, 1, T_Q, 0, 1));
    step(C_NONE, 0, 0, 1, 0, mk(5, 0, 0, 0, 1, T_Q, 0, 1));
    idle(0, mk(5, 0, 0, 0, 1, T_Q, 0, 1));
    idle(1, mk(0, 0, 0, 0, 0, T_N, 1, 0));

    // 6b: asynchronous reset in the middle of a dispense
    apply_reset();
    step(C_DOL, 0, 0, 0, 0, mk(20, 0, 0, 0, 0, T_N, 0, 0));
    step(C_NONE, 0, 0, 1, 0, mk(20, 0, 0, 0, 1, T_Q, 0, 1));
    idle(1, mk(15, 0, 0, 0, 1, T_Q, 0, 1));
    #2;
    reset = 1'b1;
    #1;
    step_no++;
    chk_all(mk(0, 0, 0, 0, 0, T_N, 0, 0));
    $display("async reset mid-dispense -> credit=%0d valid=%0d busy=%0d", credit, coin_out_valid, busy);
    @(negedge clk);
    reset = 1'b0;
    idle(1, mk(0, 0, 0, 0, 0, T_N, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
